// File: rtl/sdram_test_master_if.sv
// Request/ack bus between a client initiator and the SDRAM controller.
// Handshake: req is held with addr/rh_wl/data_w stable until a one-cycle ack
// accepts it; a read returns data later on a one-cycle data_r_en strobe.
interface sdram_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
);
    logic                  sdram_req;
    logic                  sdram_ack;
    logic [ADDR_WIDTH-1:0] sdram_addr;
    logic                  sdram_rh_wl;
    logic [DATA_WIDTH-1:0] sdram_data_w;
    logic [DATA_WIDTH-1:0] sdram_data_r;
    logic                  sdram_data_r_en;

    modport master (
        output sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w,
        input  sdram_ack, sdram_data_r, sdram_data_r_en
    );

    modport slave (
        input  sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w,
        output sdram_ack, sdram_data_r, sdram_data_r_en
    );
endinterface

// File: rtl/sdram_test_master.sv
// Two-pass SDRAM memory test initiator: writes P(a) then reads/compares, then
// repeats with ~P(a); reports error count and the first failing access.
module sdram_test_master #(
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   = '1,
    parameter logic [DATA_WIDTH-1:0] SEED       = 16'hA5C3,
    parameter int                    WR_HOLD    = 4,
    parameter int                    RD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass_ok,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_exp,
    output logic [DATA_WIDTH-1:0] err_got,
    output logic [2:0]            dbg_state,
    sdram_if.master               sdram
);

    localparam int TW = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
    // WR_HOLDS always lasts at least one cycle so req never re-rises right after ack.
    localparam logic [15:0] HOLD_LOAD = (WR_HOLD > 0) ? 16'(WR_HOLD - 1) : 16'd0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_HOLDS = 3'd2,
        RD_REQ   = 3'd3,
        RD_WAIT  = 3'd4,
        NEXT     = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  pass_q, pass_d;
    logic [15:0]           hold_q, hold_d;
    logic [TW-1:0]         to_q, to_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;
    logic [DATA_WIDTH-1:0] err_got_q, err_got_d;
    logic                  pass_ok_q, pass_ok_d;

    logic                  rec_err;
    logic                  rd_advance;
    logic [DATA_WIDTH-1:0] got_val;
    logic [DATA_WIDTH-1:0] exp_data;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic p);
        return DATA_WIDTH'(a) ^ SEED ^ {DATA_WIDTH{p}};
    endfunction

    assign exp_data = pattern(cnt_q, pass_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= START_ADDR;
            pass_q     <= 1'b0;
            hold_q     <= '0;
            to_q       <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            pass_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            hold_q     <= hold_d;
            to_q       <= to_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
            pass_ok_q  <= pass_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        hold_d     = hold_q;
        to_d       = to_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        pass_ok_d  = pass_ok_q;
        rec_err    = 1'b0;
        rd_advance = 1'b0;
        got_val    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    err_exp_d  = '0;
                    err_got_d  = '0;
                    pass_ok_d  = 1'b0;
                    pass_d     = 1'b0;
                    cnt_d      = START_ADDR;
                    state_d    = WR_REQ;
                end
            end
            WR_REQ: begin
                if (sdram.sdram_ack) begin
                    hold_d  = HOLD_LOAD;
                    state_d = WR_HOLDS;
                end
            end
            WR_HOLDS: begin
                if (hold_q == 16'd0) begin
                    if (cnt_q == END_ADDR) begin
                        cnt_d   = START_ADDR;
                        state_d = RD_REQ;
                    end else begin
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        state_d = WR_REQ;
                    end
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            RD_REQ: begin
                if (sdram.sdram_ack) begin
                    to_d    = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (sdram.sdram_data_r_en) begin
                    rd_advance = 1'b1;
                    if (sdram.sdram_data_r != exp_data) begin
                        rec_err = 1'b1;
                        got_val = sdram.sdram_data_r;
                    end
                end else if (to_q >= TW'(RD_TIMEOUT)) begin
                    rd_advance = 1'b1;
                    rec_err    = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
                if (rd_advance) begin
                    if (cnt_q == END_ADDR) begin
                        state_d = NEXT;
                    end else begin
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            NEXT: begin
                if (!pass_q) begin
                    pass_d  = 1'b1;
                    cnt_d   = START_ADDR;
                    state_d = WR_REQ;
                end else begin
                    // Latched on entry to FIN so it is already valid alongside done.
                    pass_ok_d = (err_cnt_q == 16'd0);
                    state_d   = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rec_err) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
                err_addr_d = cnt_q;
                err_exp_d  = exp_data;
                err_got_d  = got_val;
            end
        end
    end

    logic wr_phase;
    logic rd_phase;

    assign wr_phase = (state_q == WR_REQ) || (state_q == WR_HOLDS);
    assign rd_phase = (state_q == RD_REQ) || (state_q == RD_WAIT);

    assign sdram.sdram_req    = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign sdram.sdram_rh_wl  = rd_phase;
    assign sdram.sdram_addr   = (wr_phase || rd_phase) ? cnt_q : '0;
    assign sdram.sdram_data_w = wr_phase ? exp_data : '0;

    assign busy      = (state_q != IDLE) && (state_q != FIN);
    assign done      = (state_q == FIN);
    assign pass_ok   = pass_ok_q;
    assign err_cnt   = err_cnt_q;
    assign err_addr  = err_addr_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_test_master.sv
// Bench for sdram_test_master: a behavioural SDRAM responder with fault
// injection, an access scoreboard and a table of whole-test scenarios.
module tb_sdram_test_master;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass_ok;
    logic [15:0]   err_cnt;
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_exp;
    logic [DW-1:0] err_got;
    logic [2:0]    dbg_state;

    sdram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_test_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .START_ADDR(24'd0),
        .END_ADDR  (24'd7),
        .SEED      (16'hA5C3),
        .WR_HOLD   (4),
        .RD_TIMEOUT(255)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass_ok  (pass_ok),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .err_exp  (err_exp),
        .err_got  (err_got),
        .dbg_state(dbg_state),
        .sdram    (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected accesses in order: {rh_wl, addr, write data (0 for reads)}
    logic [40:0] exp_q[$];

    int      ack_delay   = 2;
    int      corrupt_idx = -1;
    int      drop_idx    = -1;
    bit      resp_abort  = 1'b0;
    int      test_id     = 0;
    int      wr_n        = 0;
    int      rd_n        = 0;
    int      done_cnt    = 0;
    logic [DW-1:0] mem[NW];
    logic [DW-1:0] wr_log[2*NW];

    typedef struct {
        int          ack_delay;
        int          corrupt;
        int          drop;
        bit          restart;
        logic [15:0] e_cnt;
        logic        e_ok;
        logic [23:0] e_addr;
        logic [15:0] e_exp;
        logic [15:0] e_got;
    } vec_t;

    vec_t tab[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a, input int p);
        logic [DW-1:0] v;
        v = DW'(a) ^ 16'hA5C3;
        if (p != 0) v = ~v;
        return v;
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // Responder: acks after ack_delay cycles, returns read data 4 cycles after ack.
    initial begin : responder
        int            phase;
        int            cnt;
        int            dly;
        int            rd_idx;
        int            last_id;
        bit            stable;
        logic [AW-1:0] a_l;
        logic [DW-1:0] d_l;
        logic          rh_l;
        logic [40:0]   e;
        phase   = 0;
        cnt     = 0;
        dly     = 2;
        rd_idx  = 0;
        last_id = -1;
        stable  = 1'b1;
        bus.sdram_ack       = 1'b0;
        bus.sdram_data_r_en = 1'b0;
        bus.sdram_data_r    = '0;
        forever begin
            @(negedge clk);
            bus.sdram_ack       = 1'b0;
            bus.sdram_data_r_en = 1'b0;
            if (resp_abort) begin
                phase = 0;
            end else begin
                if (test_id != last_id) begin
                    last_id = test_id;
                    wr_n    = 0;
                    rd_n    = 0;
                end
                case (phase)
                    0: begin
                        if (bus.sdram_req) begin
                            a_l    = bus.sdram_addr;
                            d_l    = bus.sdram_data_w;
                            rh_l   = bus.sdram_rh_wl;
                            stable = 1'b1;
                            cnt    = 1;
                            dly    = (ack_delay > 0) ? ack_delay : int'($urandom_range(2, 6));
                            phase  = 1;
                        end
                    end
                    1: begin
                        cnt++;
                        if (!bus.sdram_req || bus.sdram_addr != a_l || bus.sdram_rh_wl != rh_l ||
                            (!rh_l && bus.sdram_data_w != d_l)) stable = 1'b0;
                        if (cnt >= dly) begin
                            bus.sdram_ack = 1'b1;
                            check("req_held_stable", 64'(stable), 64'd1);
                            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                            check("access", 64'({rh_l, a_l, (rh_l ? 16'd0 : d_l)}), 64'(e));
                            cnt    = 0;
                            stable = 1'b1;
                            if (!rh_l) begin
                                mem[a_l[2:0]] = d_l;
                                if (wr_n < 2*NW) wr_log[wr_n] = d_l;
                                wr_n++;
                                phase = 3;
                            end else begin
                                rd_idx = rd_n;
                                rd_n++;
                                phase = 2;
                            end
                        end
                    end
                    2: begin
                        cnt++;
                        if (bus.sdram_req || bus.sdram_addr != a_l || !bus.sdram_rh_wl) stable = 1'b0;
                        if (cnt >= 4) begin
                            check("rd_wait_stable", 64'(stable), 64'd1);
                            if (rd_idx != drop_idx) begin
                                bus.sdram_data_r    = mem[a_l[2:0]] ^ ((rd_idx == corrupt_idx) ? 16'd1 : 16'd0);
                                bus.sdram_data_r_en = 1'b1;
                            end
                            phase = 0;
                        end
                    end
                    default: begin
                        cnt++;
                        if (bus.sdram_req || bus.sdram_addr != a_l || bus.sdram_rh_wl ||
                            bus.sdram_data_w != d_l) stable = 1'b0;
                        if (cnt >= 4) begin
                            check("wr_hold_stable", 64'(stable), 64'd1);
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic run_entry(input vec_t v, input string tag);
        int base;
        int n;
        ack_delay   = v.ack_delay;
        corrupt_idx = v.corrupt;
        drop_idx    = v.drop;
        test_id++;
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < NW; a++) exp_q.push_back({1'b0, 24'(a), pat(a, p)});
            for (int a = 0; a < NW; a++) exp_q.push_back({1'b1, 24'(a), 16'd0});
        end
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        if (v.restart) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_pass_ok"}, 64'(pass_ok), 64'(v.e_ok));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(v.e_cnt));
        check({tag, "_err_addr"}, 64'(err_addr), 64'(v.e_addr));
        check({tag, "_err_exp"}, 64'(err_exp), 64'(v.e_exp));
        check({tag, "_err_got"}, 64'(err_got), 64'(v.e_got));
        repeat (20) @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt - base), 64'd1);
        check({tag, "_accesses_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pass_ok_held"}, 64'(pass_ok), 64'(v.e_ok));
    endtask

    initial begin : main
        int n;
        tab[0] = '{ack_delay: 2,  corrupt: -1, drop: -1, restart: 1'b0, e_cnt: 16'd0, e_ok: 1'b1,
                   e_addr: 24'd0, e_exp: 16'h0000, e_got: 16'h0000};
        tab[1] = '{ack_delay: 2,  corrupt: 5,  drop: -1, restart: 1'b0, e_cnt: 16'd1, e_ok: 1'b0,
                   e_addr: 24'd5, e_exp: 16'hA5C6, e_got: 16'hA5C7};
        tab[2] = '{ack_delay: 2,  corrupt: -1, drop: 2,  restart: 1'b0, e_cnt: 16'd1, e_ok: 1'b0,
                   e_addr: 24'd2, e_exp: 16'hA5C1, e_got: 16'h0000};
        tab[3] = '{ack_delay: 50, corrupt: -1, drop: -1, restart: 1'b0, e_cnt: 16'd0, e_ok: 1'b1,
                   e_addr: 24'd0, e_exp: 16'h0000, e_got: 16'h0000};
        tab[4] = '{ack_delay: 0,  corrupt: -1, drop: -1, restart: 1'b1, e_cnt: 16'd0, e_ok: 1'b1,
                   e_addr: 24'd0, e_exp: 16'h0000, e_got: 16'h0000};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass_ok", 64'(pass_ok), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_req", 64'(bus.sdram_req), 64'd0);
        check("rst_addr", 64'(bus.sdram_addr), 64'd0);
        check("rst_data_w", 64'(bus.sdram_data_w), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_entry(tab[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("wr_addr3_pass0", 64'(wr_log[3]), 64'h A5C0);
                check("wr_addr3_pass1", 64'(wr_log[11]), 64'h5A3F);
            end
        end

        // Reset in the middle of a pass-1 read wait.
        ack_delay   = 2;
        corrupt_idx = -1;
        drop_idx    = -1;
        test_id++;
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < NW; a++) exp_q.push_back({1'b0, 24'(a), pat(a, p)});
            for (int a = 0; a < NW; a++) exp_q.push_back({1'b1, 24'(a), 16'd0});
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((rd_n < 10 || dbg_state != 3'd4) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_rd_wait", 64'(dbg_state), 64'd4);
        resp_abort = 1'b1;
        reset      = 1'b1;
        @(negedge clk);
        check("midrst_req", 64'(bus.sdram_req), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        resp_abort = 1'b0;
        exp_q.delete();
        run_entry(tab[0], "after_rst");

        // start coinciding with reset must leave the block idle.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_rst_state", 64'(dbg_state), 64'd0);
        check("start_rst_busy", 64'(busy), 64'd0);
        check("start_rst_req", 64'(bus.sdram_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_test_master.md
Name: sdram_test_master

Overview:
- Client-side initiator for the SDRAM controller's request/ack interface (`sdram_req`/`sdram_ack`/`sdram_addr`/`sdram_rh_wl`/`sdram_data_w`/`sdram_data_r`/`sdram_data_r_en`).
- Runs a two-pass memory test over a configurable address range:
  - pass 0 writes pattern P(a) to every address, then reads back and compares;
  - pass 1 repeats the write/read with ~P(a).
- Reports busy/done/pass status, an error count and first-failure capture.
- Sits in the sdram-test top level between the start button/LED logic and the controller.

Parameters:
- ADDR_WIDTH, 24, controller word-address width (bank+row+col).
- DATA_WIDTH, 16, data word width.
- START_ADDR, 0, first tested address (inclusive).
- END_ADDR, 2^24-1, last tested address (inclusive); END_ADDR >= START_ADDR.
- SEED, 16'hA5C3, pattern seed; P(a) = a[DATA_WIDTH-1:0] XOR SEED.
- WR_HOLD, 4, cycles after write ack during which addr/data/rh_wl stay stable.
- RD_TIMEOUT, 255, max cycles from read ack to `sdram_data_r_en`.

Ports:
- clk  in  1  system clock (same as controller).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a test when idle, ignored while busy.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at test end.
- pass_ok  out  1  valid after done: 1 if err_cnt==0; held until next start.
- err_cnt  out  16  mismatches + timeouts, saturates at 16'hFFFF.
- err_addr  out  ADDR_WIDTH  address of first failure.
- err_exp  out  DATA_WIDTH  expected data at first failure.
- err_got  out  DATA_WIDTH  read data at first failure (0 on timeout).
- sdram_req  out  1  request to controller.
- sdram_ack  in  1  one-cycle acceptance pulse from controller.
- sdram_addr  out  ADDR_WIDTH  request address.
- sdram_rh_wl  out  1  1=read, 0=write.
- sdram_data_w  out  DATA_WIDTH  write data.
- sdram_data_r  in  DATA_WIDTH  read data.
- sdram_data_r_en  in  1  one-cycle read-data-valid strobe.

Behaviour:
- Reset:
  - all outputs 0; state IDLE; addr counter = START_ADDR; pass = 0.
  - Reset mid-transfer drops `sdram_req` next edge and returns to IDLE.
- States:
  - IDLE: on start, clear err_cnt/err_* and pass_ok, set pass=0, addr=START_ADDR, busy=1 -> WR_REQ.
  - WR_REQ: req=1, rh_wl=0, addr=cnt, data_w=P(cnt)^{pass replicated}. On ack: req=0 the next cycle, load hold counter -> WR_HOLDS.
  - WR_HOLDS: outputs stable for WR_HOLD cycles. At expiry: if cnt==END_ADDR, set cnt=START_ADDR -> RD_REQ; else cnt+1 -> WR_REQ.
  - RD_REQ: req=1, rh_wl=1, addr=cnt. On ack: req=0 the next cycle, clear timeout counter -> RD_WAIT.
  - RD_WAIT: addr/rh_wl held stable.
    - On data_r_en, compare against the expected pattern. On mismatch: err_cnt+1; capture err_* if this is the first error.
    - If RD_TIMEOUT cycles elapse without data_r_en: count as an error, err_got=0.
    - Then, if cnt==END_ADDR -> NEXT; else cnt+1 -> RD_REQ.
  - NEXT: if pass==0: pass=1, cnt=START_ADDR -> WR_REQ. Else -> FIN.
  - FIN: done=1 for one cycle; busy=0; pass_ok=(err_cnt==0) -> IDLE.
- Handshake rules:
  - req stays high until ack is seen.
  - req is never reasserted in the ack cycle or the cycle after it, so the controller cannot start a duplicate access.
  - A data_r_en arriving in any state other than RD_WAIT is ignored.
  - An ack with req low is ignored.
- Arithmetic:
  - Address counter is ADDR_WIDTH bits; END_ADDR = 2^ADDR_WIDTH-1 terminates via the equality compare, not by wrap.
  - err_cnt saturates and never wraps.
  - Timeout counter is 8+ bits; comparison is >=.
- Simultaneous start and reset: reset wins.
- start while busy: ignored.
- START_ADDR==END_ADDR: one write and one read per pass.
- Latency: with an ideal controller (ack 2 cycles after req, data_r_en 4 cycles after ack), one word per pass is at most 2+1+WR_HOLD write + 2+4 read cycles.

Test Plan:
- Bench responder model with START_ADDR=0, END_ADDR=7 and correct storage -> 16 writes then 16 reads over two passes; done pulses once; pass_ok=1; err_cnt=0. Write data at addr 3 is 16'hA5C0 in pass 0 and 16'h5A3F in pass 1.
- Responder corrupts bit 0 of the read at addr 5, pass 0 -> err_cnt=1, err_addr=5, err_exp=16'hA5C6, err_got=16'hA5C7, pass_ok=0.
- Responder never asserts data_r_en for addr 2 -> after 255 cycles err_cnt increments, err_got=0, test continues and completes with done.
- Ack delayed 50 cycles -> req held high for all 50 cycles, addr/data stable, exactly one access per address.
- Assert reset during pass 1 RD_WAIT -> next cycle req=0, busy=0, state IDLE; a following start runs a full clean test.
- start pulsed while busy -> ignored, single done pulse; start in the same cycle as reset -> stays IDLE.
